pbus_master: RTL and testbench

// - APB-like bus initiator. Turns single-beat commands from an internal agent
//   (CPU model, register sequencer, PTP config loader) into pbus setup/access transfers.
// - Returns read data and error status on a valid/ready response channel.
// - Drives pbus slaves such as the pbus-to-ip bridge; one transfer outstanding at a time.

---
 rtl/pbus_master_pkg.sv | 14 +
 rtl/pbus_master.sv | 181 ++++++++++++++++++
 tb/tb_pbus_master.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbus_master_pkg.sv
// Shared definitions for the pbus initiator: FSM state encodings and the default timeout.
// Imported by pbus_master; the timeout itself is only built with PBUS_MASTER_TIMEOUT_EN.
package pbus_master_pkg;

  typedef enum logic [1:0] {
    PBM_IDLE   = 2'd0,
    PBM_SETUP  = 2'd1,
    PBM_ACCESS = 2'd2,
    PBM_RESP   = 2'd3
  } pbm_state_e;

  localparam int PBM_TIMEOUT_CYCLES_DEFAULT = 256;

endpackage

// File: rtl/pbus_master.sv
// APB-like pbus initiator: one outstanding single-beat transfer, response on a valid/ready channel.
// Define PBUS_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without ready.
module pbus_master
  import pbus_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = PBM_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              pbus_clk,
  input  logic              pbus_rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic [ADDR_W-1:0] pbus_addr_o,
  output logic              pbus_write_o,
  output logic              pbus_sel_o,
  output logic              pbus_enable_o,
  output logic [DATA_W-1:0] pbus_wdata_o,
  input  logic [DATA_W-1:0] pbus_rdata_i,
  input  logic              pbus_ready_i,
  input  logic              pbus_slverr_i
);

  pbm_state_e        r_state, w_state_next;

  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic              r_write, w_write_next;
  logic [DATA_W-1:0] r_wdata, w_wdata_next;
  logic              r_sel, w_sel_next;
  logic              r_enable, w_enable_next;
  logic              r_rsp_valid, w_rsp_valid_next;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_next;
  logic              r_rsp_err, w_rsp_err_next;
  logic              w_cmd_fire;

  assign cmd_ready_o = (r_state == PBM_IDLE) & ~pbus_rst;
  assign w_cmd_fire  = cmd_valid_i & cmd_ready_o;

`ifdef PBUS_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_rsp_timeout, w_rsp_timeout_next;
  logic              w_timeout_hit;

  // r_cnt counts completed ACCESS cycles, so the last allowed one sees TIMEOUT_CYCLES-1.
  assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pbus_clk) begin
    if (pbus_rst) begin
      r_cnt <= '0;
    end else if (w_cmd_fire) begin
      r_cnt <= '0;
    end else if (r_state == PBM_ACCESS) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign rsp_timeout_o = r_rsp_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign rsp_timeout_o        = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_write_next     = r_write;
    w_wdata_next     = r_wdata;
    w_sel_next       = r_sel;
    w_enable_next    = r_enable;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_err_next   = r_rsp_err;
`ifdef PBUS_MASTER_TIMEOUT_EN
    w_rsp_timeout_next = r_rsp_timeout;
`endif

    case (r_state)
      PBM_IDLE: begin
        if (w_cmd_fire) begin
          w_state_next  = PBM_SETUP;
          w_addr_next   = cmd_addr_i;
          w_write_next  = cmd_write_i;
          w_wdata_next  = cmd_wdata_i;
          w_sel_next    = 1'b1;
          w_enable_next = 1'b0;
        end
      end

      PBM_SETUP: begin
        w_state_next  = PBM_ACCESS;
        w_enable_next = 1'b1;
      end

      PBM_ACCESS: begin
        // Ready takes priority over a coincident timeout.
        if (pbus_ready_i) begin
          w_state_next     = PBM_RESP;
          w_sel_next       = 1'b0;
          w_enable_next    = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = r_write ? '0 : pbus_rdata_i;
          w_rsp_err_next   = pbus_slverr_i;
`ifdef PBUS_MASTER_TIMEOUT_EN
          w_rsp_timeout_next = 1'b0;
        end else if (w_timeout_hit) begin
          w_state_next       = PBM_RESP;
          w_sel_next         = 1'b0;
          w_enable_next      = 1'b0;
          w_rsp_valid_next   = 1'b1;
          w_rsp_rdata_next   = '0;
          w_rsp_err_next     = 1'b1;
          w_rsp_timeout_next = 1'b1;
`endif
        end
      end

      PBM_RESP: begin
        if (rsp_ready_i) begin
          w_state_next     = PBM_IDLE;
          w_rsp_valid_next = 1'b0;
        end
      end

      default: begin
        w_state_next = PBM_IDLE;
      end
    endcase
  end

  // Reset also discards any in-flight transfer and its pending response.
  always_ff @(posedge pbus_clk) begin
    if (pbus_rst) begin
      r_state     <= PBM_IDLE;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_sel       <= 1'b0;
      r_enable    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef PBUS_MASTER_TIMEOUT_EN
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_write     <= w_write_next;
      r_wdata     <= w_wdata_next;
      r_sel       <= w_sel_next;
      r_enable    <= w_enable_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
`ifdef PBUS_MASTER_TIMEOUT_EN
      r_rsp_timeout <= w_rsp_timeout_next;
`endif
    end
  end

  assign pbus_addr_o   = r_addr;
  assign pbus_write_o  = r_write;
  assign pbus_wdata_o  = r_wdata;
  assign pbus_sel_o    = r_sel;
  assign pbus_enable_o = r_enable;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;

endmodule

// File: tb/tb_pbus_master.sv
// Directed bench for pbus_master; expectations follow the timeout build when
// PBUS_MASTER_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 16 here).
module tb_pbus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] pbus_addr;
  logic        pbus_write;
  logic        pbus_sel;
  logic        pbus_enable;
  logic [31:0] pbus_wdata;
  logic [31:0] pbus_rdata;
  logic        pbus_ready;
  logic        pbus_slverr;

  int n_tests = 0;
  int n_fail  = 0;

  pbus_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .pbus_clk     (clk),
    .pbus_rst     (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .pbus_addr_o  (pbus_addr),
    .pbus_write_o (pbus_write),
    .pbus_sel_o   (pbus_sel),
    .pbus_enable_o(pbus_enable),
    .pbus_wdata_o (pbus_wdata),
    .pbus_rdata_i (pbus_rdata),
    .pbus_ready_i (pbus_ready),
    .pbus_slverr_i(pbus_slverr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({pbus_sel, pbus_enable, pbus_write} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {pbus_sel, pbus_enable, pbus_write});
    end
    n_tests++;
    if ({pbus_addr, pbus_wdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_addr_wdata: got %h expected 0", {pbus_addr, pbus_wdata});
    end
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 35'h0) begin
      n_fail++; $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
    end
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_ready_in_reset: got %b expected 0", cmd_ready);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready_after: got %b expected 1", cmd_ready);
    end
    $display("[TB] reset released");
  endtask

  task automatic test_write_basic();
    pbus_ready = 1'b1; pbus_slverr = 1'b0; rsp_ready = 1'b1; pbus_rdata = 32'hFFFF_FFFF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0040; cmd_wdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_accept: got %b expected 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if ({pbus_sel, pbus_enable} !== 2'b10) begin
      n_fail++; $display("FAIL wr_setup_sel_en: got %b expected 10", {pbus_sel, pbus_enable});
    end
    n_tests++;
    if (pbus_addr !== 32'h0000_0040 || pbus_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_setup_addr_data: got %h/%h expected 00000040/deadbeef", pbus_addr, pbus_wdata);
    end
    tick();
    n_tests++;
    if ({pbus_sel, pbus_enable, pbus_write, rsp_valid} !== 4'b1110) begin
      n_fail++; $display("FAIL wr_access: got %b expected 1110", {pbus_sel, pbus_enable, pbus_write, rsp_valid});
    end
    tick();
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_timeout, pbus_sel, pbus_enable} !== 5'b10000) begin
      n_fail++; $display("FAIL wr_rsp_flags: got %b expected 10000", {rsp_valid, rsp_err, rsp_timeout, pbus_sel, pbus_enable});
    end
    n_tests++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL wr_rsp_rdata: got %h expected 00000000", rsp_rdata);
    end
    n_tests++;
    if (pbus_addr !== 32'h0000_0040) begin
      n_fail++; $display("FAIL wr_addr_hold: got %h expected 00000040", pbus_addr);
    end
    tick();
    n_tests++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL wr_back_idle: got %b expected 01", {rsp_valid, cmd_ready});
    end
    $display("[TB] write addr=00000040 data=deadbeef err=%b", rsp_err);
  endtask

  task automatic test_read_wait();
    int en_cnt = 0;
    int lat = 0;
    bit addr_bad = 1'b0;
    pbus_ready = 1'b0; pbus_slverr = 1'b1; pbus_rdata = 32'hFFFF_FFFF; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0010; cmd_wdata = 32'h5555_5555;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      if (pbus_addr !== 32'h0000_0010) addr_bad = 1'b1;
      if (pbus_enable) begin
        en_cnt++;
        if (en_cnt == 4) begin
          pbus_ready = 1'b1; pbus_slverr = 1'b0; pbus_rdata = 32'h1234_5678;
        end
      end
    end
    pbus_ready = 1'b0; pbus_rdata = 32'h0;
    n_tests++;
    if (en_cnt !== 4) begin
      n_fail++; $display("FAIL rd_enable_cycles: got %0d expected 4", en_cnt);
    end
    n_tests++;
    if (lat !== 6) begin
      n_fail++; $display("FAIL rd_latency: got %0d expected 6", lat);
    end
    n_tests++;
    if (addr_bad !== 1'b0) begin
      n_fail++; $display("FAIL rd_addr_stable: got %b expected 0", addr_bad);
    end
    n_tests++;
    if (rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp: got %h err=%b expected 12345678 err=0", rsp_rdata, rsp_err);
    end
    tick();
    $display("[TB] read addr=00000010 data=%h waits=3", rsp_rdata);
  endtask

  task automatic test_slverr();
    pbus_ready = 1'b1; pbus_slverr = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0080; cmd_wdata = 32'h0000_00AA;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin
      n_fail++; $display("FAIL slverr_flags: got %b expected 110", {rsp_valid, rsp_err, rsp_timeout});
    end
    n_tests++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL slverr_rdata: got %h expected 00000000", rsp_rdata);
    end
    tick();
    pbus_slverr = 1'b0;
    $display("[TB] write addr=00000080 slverr err=%b", rsp_err);
  endtask

  task automatic test_timeout();
    int en_cnt = 0;
    int lat = 0;
    pbus_ready = 1'b0; pbus_slverr = 1'b0; pbus_rdata = 32'hCAFE_F00D; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0020;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      tick();
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      if (pbus_enable) en_cnt++;
    end
`ifdef PBUS_MASTER_TIMEOUT_EN
    n_tests++;
    if (lat !== 18 || en_cnt !== 16) begin
      n_fail++; $display("FAIL timeout_cycles: got lat=%0d en=%0d expected lat=18 en=16", lat, en_cnt);
    end
    n_tests++;
    if ({rsp_err, rsp_timeout, pbus_sel, pbus_enable} !== 4'b1100 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL timeout_rsp: got %b rdata=%h expected 1100 rdata=0",
                         {rsp_err, rsp_timeout, pbus_sel, pbus_enable}, rsp_rdata);
    end
    tick();
    $display("[TB] read addr=00000020 aborted by timeout");
`else
    n_tests++;
    if ({rsp_valid, pbus_sel, pbus_enable} !== 3'b011 || lat !== 0) begin
      n_fail++; $display("FAIL no_timeout_hang: got %b lat=%0d expected 011 lat=0",
                         {rsp_valid, pbus_sel, pbus_enable}, lat);
    end
    n_tests++;
    if (en_cnt !== 999) begin
      n_fail++; $display("FAIL no_timeout_en_cycles: got %0d expected 999", en_cnt);
    end
    $display("[TB] read addr=00000020 still waiting at cycle 1000");
`endif
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pbus_ready = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0030; cmd_wdata = 32'h0000_0033;
    tick();
    cmd_valid = 1'b0;
    tick();
    n_tests++;
    if ({pbus_sel, pbus_enable} !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_in_access: got %b expected 11", {pbus_sel, pbus_enable});
    end
    rst = 1'b1; pbus_ready = 1'b1;
    tick();
    n_tests++;
    if ({pbus_sel, pbus_enable, rsp_valid, cmd_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_abort: got %b expected 0000", {pbus_sel, pbus_enable, rsp_valid, cmd_ready});
    end
    rst = 1'b0; pbus_ready = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_cmd_ready: got %b expected 1", cmd_ready);
    end
    tick();
    n_tests++;
    if ({pbus_sel, rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_no_partial: got %b expected 00", {pbus_sel, rsp_valid});
    end
    $display("[TB] write addr=00000030 discarded by reset");
  endtask

  task automatic test_back_to_back();
    pbus_ready = 1'b1; pbus_slverr = 1'b0; rsp_ready = 1'b0; pbus_rdata = 32'h0BAD_F00D;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0100; cmd_wdata = 32'hA5A5_0001;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept_a: got %b expected 1", cmd_ready);
    end
    tick();
    cmd_write = 1'b0; cmd_addr = 32'h0000_0200; cmd_wdata = 32'h0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if ({rsp_valid, rsp_err, cmd_ready, pbus_sel} !== 4'b1000 || rsp_rdata !== 32'h0
          || pbus_addr !== 32'h0000_0100) begin
        n_fail++; $display("FAIL b2b_hold_%0d: got %b rdata=%h addr=%h expected 1000 rdata=0 addr=00000100",
                           k, {rsp_valid, rsp_err, cmd_ready, pbus_sel}, rsp_rdata, pbus_addr);
      end
      tick();
    end
    rsp_ready = 1'b1;
    n_tests++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_still_valid: got %b expected 1", rsp_valid);
    end
    tick();
    n_tests++;
    if ({rsp_valid, cmd_ready, pbus_sel} !== 3'b010) begin
      n_fail++; $display("FAIL b2b_idle: got %b expected 010", {rsp_valid, cmd_ready, pbus_sel});
    end
    $display("[TB] write addr=00000100 data=a5a50001 err=%b", rsp_err);
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if ({pbus_sel, pbus_enable, pbus_write} !== 3'b100 || pbus_addr !== 32'h0000_0200) begin
      n_fail++; $display("FAIL b2b_setup_b: got %b addr=%h expected 100 addr=00000200",
                         {pbus_sel, pbus_enable, pbus_write}, pbus_addr);
    end
    tick();
    tick();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL b2b_rsp_b: got valid=%b rdata=%h expected valid=1 rdata=0badf00d",
                         rsp_valid, rsp_rdata);
    end
    tick();
    $display("[TB] read addr=00000200 data=%h", rsp_rdata);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pbus_rdata = '0; pbus_ready = 1'b0; pbus_slverr = 1'b0;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
